// File: rtl/cache_write_buffer.sv
// Write buffer between a direct-mapped cache and main memory: coalescing FIFO of dirty lines,
// read forwarding on address match, and background draining while the cache is quiet.
module cache_write_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
) (
  input  logic                   clk,
  input  logic                   proc_reset,
  input  logic                   cache_read,
  input  logic                   cache_write,
  input  logic [ADDR_W-1:0]      cache_addr,
  input  logic [DATA_W-1:0]      cache_wdata,
  output logic [DATA_W-1:0]      cache_rdata,
  output logic                   cache_ready,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   mem_ready,
  output logic [$clog2(DEPTH):0] wb_count,
  output logic                   wb_empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {StIdle, StAck, StQuiet, StRd, StDrain} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ready;

  logic              w_hit;
  logic [PTR_W-1:0]  w_hit_idx;
  logic              w_full;
  logic              w_upd;
  logic              w_enq;
  logic              w_rhit;
  logic              w_rmiss;
  logic              w_rfill;
  logic              w_pop;

  // Coalescing keeps buffered addresses unique, so at most one entry can match.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_valid[i] && (r_addr[i] == cache_addr)) begin
        w_hit     = 1'b1;
        w_hit_idx = PTR_W'(i);
      end
    end
  end

  assign w_full = (r_count == CNT_W'(DEPTH));

  always_comb begin
    w_state_d = r_state;
    w_upd     = 1'b0;
    w_enq     = 1'b0;
    w_rhit    = 1'b0;
    w_rmiss   = 1'b0;
    w_rfill   = 1'b0;
    w_pop     = 1'b0;
    case (r_state)
      StIdle: begin
        if (cache_write) begin
          if (w_hit) begin
            w_upd     = 1'b1;
            w_state_d = StAck;
          end else if (!w_full) begin
            w_enq     = 1'b1;
            w_state_d = StAck;
          end else begin
            // Write stays pending and is re-sampled once a slot frees up.
            w_state_d = StDrain;
          end
        end else if (cache_read) begin
          if (w_hit) begin
            w_rhit    = 1'b1;
            w_state_d = StAck;
          end else begin
            w_rmiss   = 1'b1;
            w_state_d = StRd;
          end
        end else if (r_count != '0) begin
          w_state_d = StDrain;
        end
      end
      StAck:   w_state_d = StQuiet;
      StQuiet: w_state_d = StIdle;
      StRd: begin
        if (mem_ready) begin
          w_rfill   = 1'b1;
          w_state_d = StAck;
        end
      end
      StDrain: begin
        if (mem_ready) begin
          w_pop     = 1'b1;
          w_state_d = StQuiet;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_state   <= StIdle;
      r_valid   <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_rd_addr <= '0;
      r_rdata   <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ready <= (w_state_d == StAck);
      if (w_rmiss) r_rd_addr <= cache_addr;
      if (w_rhit) begin
        r_rdata <= r_data[w_hit_idx];
      end else if (w_rfill) begin
        r_rdata <= mem_rdata;
      end
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
        r_count         <= r_count + CNT_W'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
        r_count         <= r_count - CNT_W'(1);
      end
    end
  end

  // Payload needs no reset: an entry is only visible through its valid bit.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_tail] <= cache_addr;
      r_data[r_tail] <= cache_wdata;
    end else if (w_upd) begin
      r_data[w_hit_idx] <= cache_wdata;
    end
  end

  assign mem_read  = (r_state == StRd);
  assign mem_write = (r_state == StDrain);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (r_state == StRd) begin
      mem_addr = r_rd_addr;
    end else if (r_state == StDrain) begin
      mem_addr  = r_addr[r_head];
      mem_wdata = r_data[r_head];
    end
  end

  assign cache_rdata = r_rdata;
  assign cache_ready = r_ready;
  assign wb_count    = r_count;
  assign wb_empty    = (r_count == '0);

endmodule

// File: tb/tb_cache_write_buffer.sv
// Bench for cache_write_buffer: vector table, directed corner sequences, and random traffic
// checked against a queue-based model of the buffer plus a flat memory image.
module tb_cache_write_buffer;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              proc_reset = 1'b1;
  logic              cache_read = 1'b0;
  logic              cache_write = 1'b0;
  logic [ADDR_W-1:0] cache_addr = '0;
  logic [DATA_W-1:0] cache_wdata = '0;
  logic [DATA_W-1:0] cache_rdata;
  logic              cache_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic [CNT_W-1:0]  wb_count;
  logic              wb_empty;

  cache_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .proc_reset(proc_reset), .cache_read(cache_read), .cache_write(cache_write),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_rdata(cache_rdata),
    .cache_ready(cache_ready), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wb_count(wb_count), .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Memory responder: automatic replies after mem_lat cycles, or forced pulses via kick_req.
  bit           mem_hold = 1'b1;
  int           mem_lat = 1;
  int           mem_wait = 0;
  int           kick_req = 0;
  int           kick_done = 0;
  int           rd_cycles = 0;
  int           wr_cycles = 0;
  int           both_err = 0;
  logic [127:0] mem_img [256];
  logic [27:0]  mem_tag [256];
  bit           mem_vld [256];
  logic [27:0]  log_addr [1024];
  logic [127:0] log_data [1024];
  int           log_wr = 0;
  int           log_rd = 0;

  function automatic logic [127:0] dflt(input logic [27:0] a);
    return {4'hC, a, 4'h3, ~a, 4'h9, a ^ 28'hA5A5A5A, 4'h5, a + 28'h1234567};
  endfunction

  function automatic logic [127:0] rd_val(input logic [27:0] a);
    if (mem_vld[a[7:0]] && mem_tag[a[7:0]] == a) return mem_img[a[7:0]];
    return dflt(a);
  endfunction

  always @(posedge clk) begin
    if (mem_read && mem_write) both_err <= both_err + 1;
    if (mem_read) rd_cycles <= rd_cycles + 1;
    if (mem_write) wr_cycles <= wr_cycles + 1;
    if (mem_ready) begin
      mem_ready <= 1'b0;
      mem_wait  <= 0;
    end else if ((kick_req != kick_done) ||
                 ((mem_read || mem_write) && !mem_hold && mem_wait >= mem_lat)) begin
      if (kick_req != kick_done) kick_done <= kick_done + 1;
      mem_ready <= 1'b1;
      mem_wait  <= 0;
      if (mem_write) begin
        mem_img[mem_addr[7:0]] <= mem_wdata;
        mem_tag[mem_addr[7:0]] <= mem_addr;
        mem_vld[mem_addr[7:0]] <= 1'b1;
        log_addr[log_wr]       <= mem_addr;
        log_data[log_wr]       <= mem_wdata;
        log_wr                 <= log_wr + 1;
      end else if (mem_read) begin
        mem_rdata <= rd_val(mem_addr);
      end
    end else if ((mem_read || mem_write) && !mem_hold) begin
      mem_wait <= mem_wait + 1;
    end else begin
      mem_wait <= 0;
    end
  end

  // Reference model: buffer contents in FIFO order, plus what memory should hold.
  logic [27:0]  m_addr [$];
  logic [127:0] m_data [$];
  logic [127:0] ref_mem [logic [27:0]];
  bit           track = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic process_log();
    while (log_rd != log_wr) begin
      if (m_addr.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL drain_unexpected: got write to %h, required none", log_addr[log_rd]);
      end else begin
        chk("drain_addr", 128'(log_addr[log_rd]), 128'(m_addr[0]));
        chk("drain_data", log_data[log_rd], m_data[0]);
        ref_mem[m_addr[0]] = m_data[0];
        void'(m_addr.pop_front());
        void'(m_data.pop_front());
      end
      log_rd++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (track) process_log();
  endtask

  task automatic reset_dut();
    proc_reset  = 1'b1;
    cache_read  = 1'b0;
    cache_write = 1'b0;
    mem_hold    = 1'b1;
    tick();
    tick();
    proc_reset = 1'b0;
    log_rd     = log_wr;
  endtask

  task automatic do_req(input bit rd, input logic [27:0] a, input logic [127:0] d,
                        input int budget, output int lat, output bit ok);
    cache_read  = rd;
    cache_write = !rd;
    cache_addr  = a;
    cache_wdata = d;
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < budget) begin
      tick();
      lat++;
      if (cache_ready) ok = 1'b1;
    end
    cache_read  = 1'b0;
    cache_write = 1'b0;
  endtask

  task automatic expect_log(input string name, input logic [27:0] a, input logic [127:0] d);
    if (log_rd < log_wr) begin
      chk({name, "_addr"}, 128'(log_addr[log_rd]), 128'(a));
      chk({name, "_data"}, log_data[log_rd], d);
      log_rd++;
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got no memory write, required addr %h", name, a);
    end
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (!wb_empty && n < budget) begin
      tick();
      n++;
    end
    chk(name, 128'(wb_empty), 128'(1));
  endtask

  typedef struct {
    bit           rd;
    logic [27:0]  addr;
    logic [127:0] data;
    int           exp_lat;
    logic [127:0] exp_rdata;
    int           exp_cnt;
  } vec_t;

  localparam logic [127:0] KA = 128'hA0A0_0001_A0A0_0002_A0A0_0003_A0A0_0004;
  localparam logic [127:0] KB = 128'hB1B1_1111_B1B1_2222_B1B1_3333_B1B1_4444;
  localparam logic [127:0] KC = 128'hC2C2_0C0C_C2C2_1C1C_C2C2_2C2C_C2C2_3C3C;
  localparam logic [127:0] KD = 128'hD3D3_DDDD_0000_1111_D3D3_2222_3333_4444;
  localparam logic [127:0] KE = 128'hE4E4_5555_E4E4_6666_E4E4_7777_E4E4_8888;
  localparam logic [127:0] KF = 128'hF5F5_9999_F5F5_AAAA_F5F5_BBBB_F5F5_CCCC;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required completion within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t         tbl [10];
    int           lat;
    bit           ok;
    int           snap;
    int           n;
    bit           seen;
    bit           rd;
    bit           found;
    int           idx;
    logic [27:0]  a;
    logic [127:0] d;
    logic [127:0] exp;

    tbl[0] = '{0, 28'h0000100, KA, 1, 128'h0, 1};
    tbl[1] = '{1, 28'h0000100, '0, 3, KA, 1};
    tbl[2] = '{0, 28'h0000101, KB, 3, KA, 2};
    tbl[3] = '{0, 28'h0000100, KC, 3, KA, 2};
    tbl[4] = '{1, 28'h0000100, '0, 3, KC, 2};
    tbl[5] = '{0, 28'h0000102, KD, 3, KC, 3};
    tbl[6] = '{0, 28'h0000103, KE, 3, KC, 4};
    tbl[7] = '{0, 28'h0000101, KF, 3, KC, 4};
    tbl[8] = '{1, 28'h0000101, '0, 3, KF, 4};
    tbl[9] = '{1, 28'h0000103, '0, 3, KE, 4};

    // Reset state.
    reset_dut();
    chk("rst_cache_ready", 128'(cache_ready), 128'(0));
    chk("rst_mem_rw", 128'({mem_read, mem_write}), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_mem_wdata", mem_wdata, 128'(0));
    chk("rst_cache_rdata", cache_rdata, 128'(0));
    chk("rst_wb_count", 128'(wb_count), 128'(0));
    chk("rst_wb_empty", 128'(wb_empty), 128'(1));

    // Vector table: back-to-back requests with memory stalled, so no drain intervenes.
    for (int i = 0; i < 10; i++) begin
      do_req(tbl[i].rd, tbl[i].addr, tbl[i].data, 20, lat, ok);
      chk($sformatf("vec%0d_ready", i), 128'(ok), 128'(1));
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(tbl[i].exp_lat));
      chk($sformatf("vec%0d_rdata", i), cache_rdata, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_count", i), 128'(wb_count), 128'(tbl[i].exp_cnt));
    end
    mem_hold = 1'b0;
    mem_lat  = 1;
    wait_empty("vec_drain_empty", 100);
    expect_log("vec_drain0", 28'h0000100, KC);
    expect_log("vec_drain1", 28'h0000101, KF);
    expect_log("vec_drain2", 28'h0000102, KD);
    expect_log("vec_drain3", 28'h0000103, KE);

    // Write then drain with a hand-timed memory reply.
    reset_dut();
    cache_write = 1'b1;
    cache_addr  = 28'h0000010;
    cache_wdata = KA;
    tick();
    chk("wd_ready", 128'(cache_ready), 128'(1));
    chk("wd_count", 128'(wb_count), 128'(1));
    cache_write = 1'b0;
    tick();
    chk("wd_ready_pulse", 128'(cache_ready), 128'(0));
    tick();
    tick();
    chk("wd_mem_write", 128'(mem_write), 128'(1));
    chk("wd_mem_addr", 128'(mem_addr), 128'(28'h0000010));
    chk("wd_mem_wdata", mem_wdata, KA);
    tick();
    tick();
    kick_req++;
    tick();
    chk("wd_write_held", 128'({mem_write, mem_ready}), 128'(2'b11));
    tick();
    chk("wd_count_after", 128'(wb_count), 128'(0));
    chk("wd_empty_after", 128'(wb_empty), 128'(1));
    chk("wd_write_drop", 128'(mem_write), 128'(0));
    expect_log("wd_log", 28'h0000010, KA);

    // Read forwarded from the buffer, memory untouched.
    reset_dut();
    do_req(1'b0, 28'h0000010, KB, 20, lat, ok);
    snap = rd_cycles;
    do_req(1'b1, 28'h0000010, '0, 20, lat, ok);
    chk("fwd_latency", 128'(lat), 128'(3));
    chk("fwd_rdata", cache_rdata, KB);
    tick();
    tick();
    chk("fwd_no_mem_read", 128'(rd_cycles - snap), 128'(0));

    // Coalesce: two writes to one line leave one entry and one memory write.
    reset_dut();
    do_req(1'b0, 28'h0000020, KA, 20, lat, ok);
    do_req(1'b0, 28'h0000020, KB, 20, lat, ok);
    chk("coal_count", 128'(wb_count), 128'(1));
    mem_hold = 1'b0;
    wait_empty("coal_empty", 50);
    expect_log("coal_log", 28'h0000020, KB);
    chk("coal_single", 128'(log_wr - log_rd), 128'(0));

    // Full buffer: fifth write stalls until the head drains.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 28'h0000031 + 28'(i), KA ^ 128'(i), 20, lat, ok);
    end
    chk("full_count", 128'(wb_count), 128'(4));
    cache_write = 1'b1;
    cache_addr  = 28'h0000035;
    cache_wdata = KE;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cache_ready) seen = 1'b1;
    end
    chk("full_no_ready", 128'(seen), 128'(0));
    chk("full_drain_head", 128'({mem_write, mem_addr}), 128'({1'b1, 28'h0000031}));
    mem_hold = 1'b0;
    mem_lat  = 2;
    n = 0;
    while (!cache_ready && n < 30) begin
      tick();
      n++;
    end
    chk("full_accept_e", 128'(cache_ready), 128'(1));
    cache_write = 1'b0;
    wait_empty("full_empty", 100);
    for (int i = 0; i < 4; i++) begin
      expect_log($sformatf("full_order%0d", i), 28'h0000031 + 28'(i), KA ^ 128'(i));
    end
    expect_log("full_order4", 28'h0000035, KE);

    // Read miss jumps ahead of pending drains.
    reset_dut();
    do_req(1'b0, 28'h0000041, KB, 20, lat, ok);
    do_req(1'b0, 28'h0000042, KC, 20, lat, ok);
    snap = wr_cycles;
    cache_read = 1'b1;
    cache_addr = 28'h0000055;
    n = 0;
    while (!mem_read && n < 10) begin
      tick();
      n++;
    end
    chk("miss_mem_read", 128'({mem_read, mem_addr}), 128'({1'b1, 28'h0000055}));
    chk("miss_no_drain_first", 128'(wr_cycles - snap), 128'(0));
    kick_req++;
    n = 0;
    while (!cache_ready && n < 10) begin
      tick();
      n++;
    end
    cache_read = 1'b0;
    chk("miss_ready", 128'(cache_ready), 128'(1));
    chk("miss_rdata", cache_rdata, dflt(28'h0000055));
    tick();
    chk("miss_rdata_hold", cache_rdata, dflt(28'h0000055));
    mem_hold = 1'b0;
    mem_lat  = 1;
    wait_empty("miss_empty", 50);
    expect_log("miss_drain_a", 28'h0000041, KB);
    expect_log("miss_drain_b", 28'h0000042, KC);

    // Reset in the middle of a drain abandons it.
    reset_dut();
    do_req(1'b0, 28'h0000061, KD, 20, lat, ok);
    n = 0;
    while (!mem_write && n < 10) begin
      tick();
      n++;
    end
    chk("rstd_in_drain", 128'(mem_write), 128'(1));
    proc_reset = 1'b1;
    tick();
    proc_reset = 1'b0;
    chk("rstd_write", 128'(mem_write), 128'(0));
    chk("rstd_count", 128'({wb_count, wb_empty}), 128'({CNT_W'(0), 1'b1}));
    chk("rstd_ready", 128'(cache_ready), 128'(0));
    kick_req++;
    tick();
    tick();
    tick();
    chk("rstd_stale_ready", 128'({mem_write, mem_read, wb_count}), 128'(0));
    chk("rstd_no_write", 128'(log_wr - log_rd), 128'(0));
    do_req(1'b0, 28'h0000062, KE, 20, lat, ok);
    chk("rstd_idle_latency", 128'(lat), 128'(1));

    // Random traffic against the queue model.
    reset_dut();
    track    = 1'b1;
    mem_hold = 1'b0;
    for (int t = 0; t < 300; t++) begin
      rd      = 1'($urandom_range(0, 1));
      a       = 28'h0ABC000 + 28'($urandom_range(0, 7));
      d       = {$urandom, $urandom, $urandom, $urandom};
      mem_lat = $urandom_range(0, 3);
      do_req(rd, a, d, 200, lat, ok);
      if (!ok) begin
        n_vec++;
        n_err++;
        $display("FAIL rnd_ready: got no cache_ready on txn %0d, required one", t);
      end else begin
        found = 1'b0;
        idx   = 0;
        foreach (m_addr[k]) if (m_addr[k] == a) begin
          found = 1'b1;
          idx   = k;
        end
        if (rd) begin
          if (found) exp = m_data[idx];
          else if (ref_mem.exists(a)) exp = ref_mem[a];
          else exp = dflt(a);
          chk("rnd_rdata", cache_rdata, exp);
        end else begin
          if (found) m_data[idx] = d;
          else begin
            m_addr.push_back(a);
            m_data.push_back(d);
          end
          chk("rnd_count", 128'(wb_count), 128'(m_addr.size()));
        end
      end
      repeat ($urandom_range(0, 5)) tick();
    end
    wait_empty("rnd_empty", 200);
    tick();
    chk("rnd_model_empty", 128'(m_addr.size()), 128'(0));
    chk("mem_rw_exclusive", 128'(both_err), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
